// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS instruction-fetch front end.
//   - ADDR_W_DEF / DATA_W_DEF : default PC and instruction widths
//   - NOP_INSTR               : encoding driven on the instruction output when
//                               the queue head is not valid
//   - fetch_entry_t           : one queue entry {instr, pc_plus4} at the
//                               default widths
//   - fetch_cnt_w()           : width of an occupancy counter for a depth
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0] pc_plus4;
  } fetch_entry_t;

  // Counter must be able to hold the value DEPTH itself, not just DEPTH-1.
  function automatic int fetch_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Generic synchronous FIFO with a synchronous flush. Storage is a plain
//   array; the head entry is read combinationally from rd_ptr so the data
//   outputs come straight from storage registers.
//
//   Ports
//     clk          rising-edge clock
//     reset        synchronous active-high reset (empties the FIFO)
//     flush_i      synchronous flush, overrides push and pop
//     push_i       write push_data_i at the tail
//     push_data_i  entry to write
//     pop_i        discard the head entry
//     valid_o      head entry is valid (FIFO not empty)
//     pop_data_o   head entry, forced to zero when empty
//     count_o      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_i,
  input  logic                             push_i,
  input  logic [WIDTH-1:0]                 push_data_i,
  input  logic                             pop_i,
  output logic                             valid_o,
  output logic [WIDTH-1:0]                 pop_data_o,
  output logic [fetch_cnt_w(DEPTH)-1:0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fetch_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic wr_en;
  logic rd_en;

  // A flush cancels whatever else happens this cycle.
  assign wr_en = push_i & ~flush_i;
  assign rd_en = pop_i  & ~flush_i & (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is natural overflow.
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale contents are masked by valid_o.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o    = (count_q != '0);
  assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end for the 5-stage MIPS pipeline. Holds the
//   fetch PC, issues reads to a one-cycle-latency instruction memory, and
//   buffers returned words in a DEPTH-entry queue that feeds IF/ID. A credit
//   rule keeps requests in flight from ever overflowing the queue; a taken
//   branch flushes the queue, drops any returning word and redirects fetch.
//
//   Ports
//     clk           rising-edge clock
//     reset         synchronous active-high reset
//     imem_req      instruction-memory read request this cycle
//     imem_addr     read address (always the current fetch PC)
//     imem_rdata    read data, valid the cycle after imem_req
//     out_valid     queue head valid
//     out_ready     IF/ID accepts the head (not held)
//     out_instr     head instruction (NOP when out_valid = 0)
//     out_pc_plus4  head PC + 4 (zero when out_valid = 0)
//     redirect      taken branch from ID
//     redirect_pc   branch target
//     count         current queue occupancy
// ---------------------------------------------------------------------------
module fetch_queue
  import mips_pkg::*;
#(
  parameter int                 ADDR_W   = ADDR_W_DEF,
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           imem_req,
  output logic [ADDR_W-1:0]              imem_addr,
  input  logic [DATA_W-1:0]              imem_rdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_instr,
  output logic [ADDR_W-1:0]              out_pc_plus4,
  input  logic                           redirect,
  input  logic [ADDR_W-1:0]              redirect_pc,
  output logic [fetch_cnt_w(DEPTH)-1:0]  count
);

  localparam int CNT_W   = fetch_cnt_w(DEPTH);
  localparam int CRED_W  = CNT_W + 1;
  localparam int ENTRY_W = DATA_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] tag_q,      tag_d;
  logic              inflight_q, inflight_d;

  logic [ADDR_W-1:0]  pc_plus4;
  logic [CRED_W-1:0]  occupancy;
  logic [CRED_W-1:0]  limit;
  logic               issue;
  logic               pop;
  logic               push;

  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               head_valid;
  logic [CNT_W-1:0]   fifo_count;

  // A branch in ID means the head belongs to the wrong path: never hand it on.
  assign pop = head_valid & out_ready & ~redirect;

  // Credit rule: entries held plus words still returning must leave room,
  // counting the slot freed by a pop this cycle. One extra bit keeps
  // DEPTH + 1 representable.
  assign occupancy = CRED_W'(fifo_count) + CRED_W'(inflight_q);
  assign limit     = CRED_W'(DEPTH) + CRED_W'(pop);
  assign issue     = ~reset & ~redirect & (occupancy < limit);

  assign pc_plus4 = fetch_pc_q + ADDR_W'(4);

  // A response arriving alongside a redirect is from the old path; drop it.
  assign push       = inflight_q & ~redirect;
  assign push_entry = {imem_rdata, tag_q};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = pc_plus4;
      tag_d      = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .valid_o     (head_valid),
    .pop_data_o  (head_entry),
    .count_o     (fifo_count)
  );

  assign imem_req     = issue;
  assign imem_addr    = fetch_pc_q;
  assign out_valid    = head_valid;
  assign out_instr    = head_valid ? head_entry[ADDR_W +: DATA_W] : DATA_W'(NOP_INSTR);
  assign out_pc_plus4 = head_entry[ADDR_W-1:0];
  assign count        = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. Two instances share control inputs:
// dut_a with RESET_PC = 0 and dut_b with RESET_PC = 0xFFFF_FFFC.
// Each has its own one-cycle memory returning 0x1000_0000 + word index.
module tb_fetch_queue;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        a_req,   b_req;
  logic [31:0] a_addr,  b_addr;
  logic [31:0] a_rdata, b_rdata;
  logic        a_valid, b_valid;
  logic [31:0] a_instr, b_instr;
  logic [31:0] a_pc4,   b_pc4;
  logic [2:0]  a_count, b_count;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .imem_req(a_req), .imem_addr(a_addr), .imem_rdata(a_rdata),
    .out_valid(a_valid), .out_ready(out_ready), .out_instr(a_instr), .out_pc_plus4(a_pc4),
    .redirect(redirect), .redirect_pc(redirect_pc), .count(a_count)
  );

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset), .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .out_valid(b_valid), .out_ready(out_ready), .out_instr(b_instr), .out_pc_plus4(b_pc4),
    .redirect(redirect), .redirect_pc(redirect_pc), .count(b_count)
  );

  function automatic logic [31:0] memword(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  always @(posedge clk) begin
    if (a_req) a_rdata <= memword(a_addr);
    if (b_req) b_rdata <= memword(b_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pc4);
    check({tag, "_valid"}, {31'b0, a_valid}, 32'd1);
    check({tag, "_instr"}, a_instr, instr);
    check({tag, "_pc4"},   a_pc4,   pc4);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One line per delivered instruction, plus a guard against pushing into a full queue.
  always @(negedge clk) begin
    #2;
    if (a_valid && out_ready && !redirect)
      $display("pop a: pc4=%h instr=%h count=%0d", a_pc4, a_instr, a_count);
    if (!reset)
      check("no_push_into_full",
            {31'b0, (dut_a.count == 3'(DEPTH)) && dut_a.push && !dut_a.pop}, 32'd0);
  end

  initial begin
    reset       = 1'b1;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // ---------------- reset state ----------------
    @(negedge clk);
    next_cycle();
    #1;
    check("rst_req",     {31'b0, a_req},   32'd0);
    check("rst_addr",    a_addr,           32'h0);
    check("rst_valid",   {31'b0, a_valid}, 32'd0);
    check("rst_count",   {29'b0, a_count}, 32'd0);
    check("rst_instr",   a_instr,          32'h0);
    check("rst_pc4",     a_pc4,            32'h0);
    check("rst_b_addr",  b_addr,           32'hFFFF_FFFC);
    check("rst_b_req",   {31'b0, b_req},   32'd0);

    // ---------------- A: fetch latency, stall fill and drain ----------------
    reset = 1'b0;  // cycle 0
    #1;
    check("a0_req",   {31'b0, a_req},   32'd1);
    check("a0_addr",  a_addr,           32'h0);
    check("a0_valid", {31'b0, a_valid}, 32'd0);
    check("a0_b_addr", b_addr,          32'hFFFF_FFFC);
    for (int c = 1; c <= 17; c++) begin
      next_cycle();
      out_ready = !(c >= 3 && c <= 12);
      #1;
      case (c)
        1: begin
          check("a1_addr",   a_addr,           32'h4);
          check("a1_req",    {31'b0, a_req},   32'd1);
          check("a1_valid",  {31'b0, a_valid}, 32'd0);
          check("a1_b_addr", b_addr,           32'h0);
        end
        2: begin
          check_head("a2", 32'h1000_0000, 32'h4);
          check("a2_addr",   a_addr,           32'h8);
          check("a2_b_valid", {31'b0, b_valid}, 32'd1);
          check("a2_b_instr", b_instr,          32'h4FFF_FFFF);
          check("a2_b_pc4",   b_pc4,            32'h0);
        end
        3: begin
          check_head("a3", 32'h1000_0001, 32'h8);
          check("a3_count",   {29'b0, a_count}, 32'd1);
          check("a3_b_instr", b_instr,          32'h1000_0000);
          check("a3_b_pc4",   b_pc4,            32'h4);
        end
        4: check("a4_count", {29'b0, a_count}, 32'd2);
        5: begin
          check("a5_count", {29'b0, a_count}, 32'd3);
          check("a5_req",   {31'b0, a_req},   32'd0);
        end
        6: begin
          check("a6_count", {29'b0, a_count}, 32'd4);
          check("a6_req",   {31'b0, a_req},   32'd0);
        end
        12: begin
          check("a12_count", {29'b0, a_count}, 32'd4);
          check("a12_req",   {31'b0, a_req},   32'd0);
          check_head("a12", 32'h1000_0001, 32'h8);
        end
        13: begin
          check("a13_req",  {31'b0, a_req}, 32'd1);
          check("a13_addr", a_addr,         32'h14);
          check_head("a13", 32'h1000_0001, 32'h8);
        end
        14: check_head("a14", 32'h1000_0002, 32'hC);
        15: check_head("a15", 32'h1000_0003, 32'h10);
        16: check_head("a16", 32'h1000_0004, 32'h14);
        17: check_head("a17", 32'h1000_0005, 32'h18);
        default: ;
      endcase
    end

    // ---------------- B: redirect with response in flight ----------------
    reset     = 1'b1;
    out_ready = 1'b1;
    next_cycle();
    reset = 1'b0;  // cycle 0
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      redirect    = (c == 6);
      redirect_pc = 32'h40;
      #1;
      case (c)
        5: begin
          check_head("b5", 32'h1000_0003, 32'h10);
          check("b5_count", {29'b0, a_count}, 32'd1);
        end
        6: begin
          check_head("b6", 32'h1000_0004, 32'h14);
          check("b6_req", {31'b0, a_req}, 32'd0);
        end
        7: begin
          check("b7_count", {29'b0, a_count}, 32'd0);
          check("b7_valid", {31'b0, a_valid}, 32'd0);
          check("b7_addr",  a_addr,           32'h40);
          check("b7_req",   {31'b0, a_req},   32'd1);
        end
        8: begin
          check("b8_valid", {31'b0, a_valid}, 32'd0);
          check("b8_addr",  a_addr,           32'h44);
        end
        9:  check_head("b9",  32'h1000_0010, 32'h44);
        10: check_head("b10", 32'h1000_0011, 32'h48);
        default: ;
      endcase
    end
    redirect = 1'b0;

    // ---------------- C: reset mid-operation ----------------
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;  // cycle 0
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      out_ready = !(c >= 3 && c <= 5);
      reset     = (c == 5);
      #1;
      case (c)
        4: check("c4_count", {29'b0, a_count}, 32'd2);
        5: begin
          check("c5_count", {29'b0, a_count}, 32'd3);
          check("c5_req",   {31'b0, a_req},   32'd0);
        end
        6: begin
          check("c6_valid",  {31'b0, a_valid}, 32'd0);
          check("c6_count",  {29'b0, a_count}, 32'd0);
          check("c6_addr",   a_addr,           32'h0);
          check("c6_req",    {31'b0, a_req},   32'd1);
          check("c6_b_addr", b_addr,           32'hFFFF_FFFC);
        end
        7: begin
          check("c7_addr",  a_addr,           32'h4);
          check("c7_valid", {31'b0, a_valid}, 32'd0);
        end
        8: check_head("c8", 32'h1000_0000, 32'h4);
        9: check_head("c9", 32'h1000_0001, 32'h8);
        default: ;
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
